// File: rtl/gray_counter.sv
// Enable-gated Gray-code counter with a wrap flag; Overflow is sticky by default,
// or a one-cycle pulse per wrap when GRAY_OVF_PULSE_EN is defined.
module gray_counter #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    output logic [WIDTH-1:0] Output,
    output logic             Overflow
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             wrap;

    assign wrap = &bin_q;

    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        if (En) begin
            bin_d  = bin_q + WIDTH'(1);
            gray_d = bin_d ^ (bin_d >> 1);
        end
`ifdef GRAY_OVF_PULSE_EN
        // High only for the cycle following a wrap edge, regardless of En afterwards.
        ovf_d = En & wrap;
`else
        ovf_d = ovf_q | (En & wrap);
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin_q  <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
        end
    end

    // Gray value is kept in its own register so Output has no combinational path.
    assign Output   = gray_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_gray_counter.sv
// Table-driven scoreboard bench for gray_counter (WIDTH=3); Overflow expectations
// follow the sticky or pulse build depending on GRAY_OVF_PULSE_EN.
module tb_gray_counter;

    typedef struct {
        bit       rst;
        bit       en;
        bit [2:0] exp_out;
        bit       exp_ovf_sticky;
        bit       exp_ovf_pulse;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       En = 1'b0;
    logic [2:0] Output;
    logic       Overflow;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    gray_counter #(.WIDTH(3)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .En(En),
        .Output(Output),
        .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic add(input bit rst, input bit en, input bit [2:0] o,
                       input bit ovs, input bit ovp);
        vec_t v;
        v.rst = rst; v.en = en; v.exp_out = o;
        v.exp_ovf_sticky = ovs; v.exp_ovf_pulse = ovp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t       e;
        logic [2:0] prev;
        bit         exp_ovf;

        // reset state
        add(1, 0, 3'b000, 0, 0);
        add(1, 1, 3'b000, 0, 0);
        // first full cycle, wrap on the 8th edge
        add(0, 1, 3'b001, 0, 0);
        add(0, 1, 3'b011, 0, 0);
        add(0, 1, 3'b010, 0, 0);
        add(0, 1, 3'b110, 0, 0);
        add(0, 1, 3'b111, 0, 0);
        add(0, 1, 3'b101, 0, 0);
        add(0, 1, 3'b100, 0, 0);
        add(0, 1, 3'b000, 1, 1);
        // ten more edges: sticky stays set, pulse fires again at edge 16
        add(0, 1, 3'b001, 1, 0);
        add(0, 1, 3'b011, 1, 0);
        add(0, 1, 3'b010, 1, 0);
        add(0, 1, 3'b110, 1, 0);
        add(0, 1, 3'b111, 1, 0);
        add(0, 1, 3'b101, 1, 0);
        add(0, 1, 3'b100, 1, 0);
        add(0, 1, 3'b000, 1, 1);
        add(0, 1, 3'b001, 1, 0);
        add(0, 1, 3'b011, 1, 0);
        // reach 111 with Overflow set, then reset mid-sequence with En=1
        add(0, 1, 3'b010, 1, 0);
        add(0, 1, 3'b110, 1, 0);
        add(0, 1, 3'b111, 1, 0);
        add(1, 1, 3'b000, 0, 0);
        add(1, 1, 3'b000, 0, 0);
        add(0, 1, 3'b001, 0, 0);
        // hold test from a clean reset
        add(1, 0, 3'b000, 0, 0);
        add(0, 1, 3'b001, 0, 0);
        add(0, 1, 3'b011, 0, 0);
        add(0, 1, 3'b010, 0, 0);
        add(0, 1, 3'b110, 0, 0);
        add(0, 0, 3'b110, 0, 0);
        add(0, 0, 3'b110, 0, 0);
        add(0, 1, 3'b111, 0, 0);
        add(0, 1, 3'b101, 0, 0);
        // wrap followed by holds: sticky keeps 1, pulse drops on the hold edge
        add(0, 1, 3'b100, 0, 0);
        add(0, 1, 3'b000, 1, 1);
        add(0, 0, 3'b000, 1, 0);
        add(0, 0, 3'b000, 1, 0);
        add(0, 1, 3'b001, 1, 0);
        // wrap, then count immediately: pulse must drop on a counting edge too
        add(0, 1, 3'b011, 1, 0);
        add(0, 1, 3'b010, 1, 0);
        add(0, 1, 3'b110, 1, 0);
        add(0, 1, 3'b111, 1, 0);
        add(0, 1, 3'b101, 1, 0);
        add(0, 1, 3'b100, 1, 0);
        add(0, 1, 3'b000, 1, 1);
        add(0, 1, 3'b001, 1, 0);
        // reset overrides a hold too
        add(1, 0, 3'b000, 0, 0);
        add(0, 0, 3'b000, 0, 0);

        prev = 3'b000;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            Reset = vecs[i].rst;
            En    = vecs[i].en;
            sb.push_back(vecs[i]);
            @(posedge Clk);
            #1;
            e = sb.pop_front();
`ifdef GRAY_OVF_PULSE_EN
            exp_ovf = e.exp_ovf_pulse;
`else
            exp_ovf = e.exp_ovf_sticky;
`endif
            check($sformatf("vec%0d Output", i), int'(Output), int'(e.exp_out));
            check($sformatf("vec%0d Overflow", i), int'(Overflow), int'(exp_ovf));
            if (!e.rst && e.en)
                check($sformatf("vec%0d one-bit step", i), $countones(prev ^ Output), 1);
            prev = Output;
        end

        check("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
